baud_tick_gen: RTL
==================

Name: baud_tick_gen

Overview:
Parametrised, runtime-programmable baud-rate generator for the UART path. It divides clk_in by a programmable divisor to produce three outputs: a one-cycle oversample tick, a one-cycle baud tick every OVERSAMPLE oversample ticks, and a near-50% square clock. Divisor updates are glitch-free: a new value is held pending and applied only at a period boundary. UART RX/TX consume the ticks as clock enables on the system clock domain.

Parameters:
CNT_W, 16, width of divisor and period counter.
DEFAULT_DIV, 651, divisor after reset (100 MHz / 651 ≈ 16 × 9600). Must satisfy 2 ≤ DEFAULT_DIV < 2^CNT_W, checked at elaboration.
OVERSAMPLE, 16, oversample ticks per baud tick. Must be ≥ 2.

Ports:
clk_in  input  1  system clock; all logic on its rising edge.
rst_n  input  1  synchronous active-low reset.
en  input  1  run enable; 0 clears and holds the counters.
div_in  input  CNT_W  new divisor value.
div_wr  input  1  one-cycle strobe that captures div_in.
os_tick  output  1  one-cycle pulse, once per divisor period.
baud_tick  output  1  one-cycle pulse, once per OVERSAMPLE os_ticks.
clk_out  output  1  square wave with period div_cur.
os_phase  output  $clog2(OVERSAMPLE)  index of the current oversample slot.
div_busy  output  1  a written divisor is pending and not yet applied.
div_err  output  1  sticky flag: an illegal divisor (<2) was written.

Behaviour:
- Reset (rst_n=0 at an edge):
  - cnt=0, os_phase=0, div_cur=DEFAULT_DIV, div_pend=DEFAULT_DIV.
  - os_tick, baud_tick, clk_out, div_busy and div_err all = 0.
  - Reset mid-period or mid-update discards any pending divisor.
- Divisor write:
  - Effective value v = (div_in < 2) ? 2 : div_in.
  - div_err is set on an illegal write, cleared by a legal write, and otherwise holds.
- en=1, per edge:
  - If cnt == div_cur-1 (terminal):
    - cnt <= 0, os_tick <= 1.
    - os_phase <= (os_phase == OVERSAMPLE-1) ? 0 : os_phase+1.
    - baud_tick <= (os_phase == OVERSAMPLE-1).
  - Otherwise: cnt <= cnt+1, os_tick <= 0, baud_tick <= 0.
  - clk_out <= (cnt < div_cur>>1), evaluated on the current cnt.
    - Even divisor: high div/2 cycles, low div/2 cycles.
    - Odd divisor: high floor(div/2) cycles, low ceil(div/2) cycles.
- Latency:
  - With en held at 1 from reset release, the first os_tick is high in the cycle after the DEFAULT_DIV-th enabled edge.
  - os_tick period thereafter = div_cur cycles. baud_tick period = OVERSAMPLE × div_cur cycles.
  - baud_tick is always coincident with an os_tick.
- Divisor update, en=1:
  - div_wr on a non-terminal edge: div_pend <= v, div_busy <= 1. The current period completes with the old div_cur.
  - At the next terminal edge: div_cur <= div_pend, div_busy <= 0.
  - div_wr on a terminal edge: div_cur <= v directly and div_busy <= 0. Any earlier pending value is overwritten.
  - Repeated writes before the terminal edge: the last one wins.
- Divisor update, en=0: div_wr sets div_cur <= v and div_pend <= v immediately; div_busy stays 0.
- en=0:
  - cnt <= 0, os_phase <= 0.
  - os_tick, baud_tick, clk_out <= 0.
  - div_busy: a pending value is applied immediately and div_busy <= 0.
- en 0→1: counting restarts from cnt=0, so a fresh full period precedes the first os_tick.
- Arithmetic:
  - cnt is CNT_W bits wide and never exceeds div_cur-1.
  - Comparisons are unsigned. No wrap-around beyond the terminal count is possible.

Test Plan:
1. DEFAULT_DIV=5, OVERSAMPLE=4, en=1 after reset → os_tick on cycles 5, 10, 15, 20…; baud_tick only on cycle 20, then 40; os_phase steps 1, 2, 3, 0; clk_out pattern 1,1,0,0,0 repeating.
2. Mid-period div_wr with div_in=8 while cnt=2 → div_busy=1 until the terminal edge; the current period stays 5 cycles; following os_tick spacing = 8; clk_out high 4, low 4.
3. div_wr on the exact terminal edge with div_in=3 → the next period is 3 cycles and div_busy never asserts. A second test writes 7 then 9 within one period → only 9 takes effect.
4. div_in=0 and div_in=1 → divisor clamped to 2; os_tick every 2 cycles; clk_out toggles each cycle; div_err=1 until a write of 6 clears it.
5. en dropped at cnt=3, os_phase=2, with a pending divisor → all outputs 0 next cycle; pending divisor applied and div_busy=0; en re-raised → first os_tick exactly div_cur cycles later, os_phase restarts from 0.
6. rst_n=0 mid-period with a pending divisor of 8 → after reset, div_cur=5, div_busy=0, div_err=0; outputs 0 while rst_n=0 and resume with a 5-cycle period.

Source files
------------

// File: rtl/baud_tick_gen.sv
// Programmable baud generator: os_tick every div_cur clocks, baud_tick every OVERSAMPLE os_ticks, square clk_out.
// Outputs are registered and change one edge after the count that causes them; no backpressure, ticks are clock enables.
module baud_tick_gen #(
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 651,
  parameter int OVERSAMPLE  = 16
) (
  input  logic                          clk_in,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [CNT_W-1:0]              div_in,
  input  logic                          div_wr,
  output logic                          os_tick,
  output logic                          baud_tick,
  output logic                          clk_out,
  output logic [$clog2(OVERSAMPLE)-1:0] os_phase,
  output logic                          div_busy,
  output logic                          div_err
);

  localparam int PH_W = $clog2(OVERSAMPLE);

  localparam logic [CNT_W-1:0] DIV_RST  = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] DIV_MIN  = CNT_W'(2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(OVERSAMPLE - 1);
  localparam logic [PH_W-1:0]  PH_ONE   = PH_W'(1);

  if (DEFAULT_DIV < 2 || longint'(DEFAULT_DIV) >= (longint'(1) << CNT_W)) begin : g_bad_div
    $error("baud_tick_gen: DEFAULT_DIV out of range");
  end
  if (OVERSAMPLE < 2) begin : g_bad_os
    $error("baud_tick_gen: OVERSAMPLE must be at least 2");
  end

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div_cur;
  logic [CNT_W-1:0] div_pend;
  logic [CNT_W-1:0] div_eff;
  logic             div_illegal;
  logic             at_term;

  always_comb begin
    div_illegal = (div_in < DIV_MIN);
    div_eff     = div_illegal ? DIV_MIN : div_in;
    at_term     = (cnt == div_cur - CNT_ONE);
  end

  // div_pend mirrors div_cur whenever div_busy is low, so applying it is always safe.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      cnt       <= '0;
      os_phase  <= '0;
      div_cur   <= DIV_RST;
      div_pend  <= DIV_RST;
      os_tick   <= 1'b0;
      baud_tick <= 1'b0;
      clk_out   <= 1'b0;
      div_busy  <= 1'b0;
      div_err   <= 1'b0;
    end else begin
      if (div_wr) begin
        div_err <= div_illegal;
      end
      if (!en) begin
        cnt       <= '0;
        os_phase  <= '0;
        os_tick   <= 1'b0;
        baud_tick <= 1'b0;
        clk_out   <= 1'b0;
        div_busy  <= 1'b0;
        if (div_wr) begin
          div_cur  <= div_eff;
          div_pend <= div_eff;
        end else begin
          div_cur  <= div_pend;
        end
      end else begin
        clk_out <= (cnt < (div_cur >> 1));
        if (at_term) begin
          cnt       <= '0;
          os_tick   <= 1'b1;
          baud_tick <= (os_phase == PH_LAST);
          os_phase  <= (os_phase == PH_LAST) ? '0 : os_phase + PH_ONE;
          div_busy  <= 1'b0;
          // A write landing on the boundary edge takes effect for the very next period.
          if (div_wr) begin
            div_cur  <= div_eff;
            div_pend <= div_eff;
          end else begin
            div_cur  <= div_pend;
          end
        end else begin
          cnt       <= cnt + CNT_ONE;
          os_tick   <= 1'b0;
          baud_tick <= 1'b0;
          if (div_wr) begin
            div_pend <= div_eff;
            div_busy <= 1'b1;
          end
        end
      end
    end
  end

endmodule
